// File: rtl/lab3_mem_blocking_cache_param_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lab3_mem_blocking_cache_param_if
// Brief    : Generic val/rdy channel carrying one flat message vector.
//            Message layouts used by the cache:
//              mem_req_4B   (77b) : type[76:74] opaque[73:66] addr[65:34] len[33:32] data[31:0]
//              mem_resp_4B  (47b) : type[46:44] opaque[43:36] test[35:34] len[33:32] data[31:0]
//              mem_req_16B (175b) : type[174:172] opaque[171:164] addr[163:132] len[131:128] data[127:0]
//              mem_resp_16B(145b) : type[144:142] opaque[141:134] test[133:132] len[131:128] data[127:0]
// Revision : 1.0 - initial release
// ============================================================================
interface lab3_mem_blocking_cache_param_if #(
   parameter int MSG_W = 77
);
   logic             val;
   logic             rdy;
   logic [MSG_W-1:0] msg;

   modport master (output val, output msg, input rdy);
   modport slave  (input val, input msg, output rdy);
endinterface
`default_nettype wire

// File: rtl/lab3_mem_blocking_cache_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lab3_mem_blocking_cache_param
// Brief    : Direct-mapped, write-back, write-allocate blocking cache between
//            a 4B processor port and a 16B memory port. Only dirty lines are
//            written back on a conflict miss.
// Revision : 1.0 - initial release
// ============================================================================
module lab3_mem_blocking_cache_param #(
   parameter int p_num_lines = 16,
   parameter int p_idx_shamt = 0
) (
   input  logic                            clk,
   input  logic                            reset,
   lab3_mem_blocking_cache_param_if.slave  cachereq,
   lab3_mem_blocking_cache_param_if.master cacheresp,
   lab3_mem_blocking_cache_param_if.master memreq,
   lab3_mem_blocking_cache_param_if.slave  memresp
);
   localparam int         c_idx_w      = (p_num_lines > 1) ? $clog2(p_num_lines) : 1;
   localparam logic [2:0] c_type_read  = 3'd0;
   localparam logic [2:0] c_type_write = 3'd1;
   localparam logic [2:0] c_type_init  = 3'd2;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,  ST_TC = 4'd1,  ST_IN = 4'd2,  ST_RD = 4'd3,
      ST_WD   = 4'd4,  ST_EP = 4'd5,  ST_ER = 4'd6,  ST_EW = 4'd7,
      ST_RR   = 4'd8,  ST_RW = 4'd9,  ST_RU = 4'd10, ST_W  = 4'd11
   } state_t;

   state_t               r_state;
   logic [2:0]           r_type;
   logic [7:0]           r_opaque;
   logic [31:0]          r_addr;
   logic [31:0]          r_data;
   logic                 r_hit;
   logic [127:0]         r_line;
   logic [p_num_lines-1:0] r_valid;
   logic [p_num_lines-1:0] r_dirty;
   logic [27:0]          r_tag_array  [p_num_lines];
   logic [127:0]         r_data_array [p_num_lines];

   logic                 r_cachereq_rdy;
   logic                 r_cacheresp_val;
   logic [46:0]          r_cacheresp_msg;
   logic                 r_memreq_val;
   logic [174:0]         r_memreq_msg;
   logic                 r_memresp_rdy;

   logic [c_idx_w-1:0]   w_idx;
   logic [27:0]          w_tag;
   logic [1:0]           w_word;
   logic                 w_is_write;
   logic                 w_is_init;
   logic                 w_hit;
   logic [127:0]         w_line_rd;
   logic [31:0]          w_word_rd;
   logic [15:0]          w_word_be;
   logic [15:0]          w_arr_be;
   logic [127:0]         w_arr_wdata;
   logic                 w_tag_we;

   // Address decomposition of the latched request; the tag keeps all 28 bits
   // so it stays correct whatever the line count or index shift.
   assign w_idx      = r_addr[4+p_idx_shamt +: c_idx_w];
   assign w_tag      = r_addr[31:4];
   assign w_word     = r_addr[3:2];
   assign w_is_write = (r_type == c_type_write);
   assign w_is_init  = (r_type == c_type_init);
   assign w_hit      = r_valid[w_idx] && (r_tag_array[w_idx] == w_tag);
   assign w_line_rd  = r_data_array[w_idx];
   assign w_word_rd  = w_line_rd[{w_word, 5'b00000} +: 32];
   assign w_word_be  = 16'h000F << {w_word, 2'b00};

   assign cachereq.rdy  = r_cachereq_rdy;
   assign cacheresp.val = r_cacheresp_val;
   assign cacheresp.msg = r_cacheresp_msg;
   assign memreq.val    = r_memreq_val;
   assign memreq.msg    = r_memreq_msg;
   assign memresp.rdy   = r_memresp_rdy;

   // Array write controls: single-word writes for INIT/WRITE, full line on refill.
   always_comb begin
      w_arr_be    = '0;
      w_arr_wdata = {4{r_data}};
      w_tag_we    = 1'b0;
      case (r_state)
         ST_IN: begin
            w_arr_be = w_word_be;
            w_tag_we = 1'b1;
         end
         ST_WD: w_arr_be = w_word_be;
         ST_RU: begin
            w_arr_be    = '1;
            w_arr_wdata = r_line;
            w_tag_we    = 1'b1;
         end
         default: ;
      endcase
   end

   // Tag and data storage; contents are qualified by the valid bits, so no reset.
   always_ff @(posedge clk) begin
      if (w_tag_we)
         r_tag_array[w_idx] <= w_tag;
      for (int b = 0; b < 16; b++)
         if (w_arr_be[b])
            r_data_array[w_idx][8*b +: 8] <= w_arr_wdata[8*b +: 8];
   end

   // Control FSM with registered handshake outputs and per-line valid/dirty state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state         <= ST_IDLE;
         r_type          <= '0;
         r_opaque        <= '0;
         r_addr          <= '0;
         r_data          <= '0;
         r_hit           <= 1'b0;
         r_line          <= '0;
         r_valid         <= '0;
         r_dirty         <= '0;
         r_cachereq_rdy  <= 1'b0;
         r_cacheresp_val <= 1'b0;
         r_cacheresp_msg <= '0;
         r_memreq_val    <= 1'b0;
         r_memreq_msg    <= '0;
         r_memresp_rdy   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cachereq_rdy <= 1'b1;
               if (cachereq.val && r_cachereq_rdy) begin
                  r_type         <= cachereq.msg[76:74];
                  r_opaque       <= cachereq.msg[73:66];
                  r_addr         <= cachereq.msg[65:34];
                  r_data         <= cachereq.msg[31:0];
                  r_cachereq_rdy <= 1'b0;
                  r_state        <= ST_TC;
               end
            end
            ST_TC: begin
               r_hit <= w_hit && !w_is_init;
               if (w_is_init)
                  r_state <= ST_IN;
               else if (w_hit)
                  r_state <= w_is_write ? ST_WD : ST_RD;
               else if (r_valid[w_idx] && r_dirty[w_idx])
                  r_state <= ST_EP;
               else begin
                  r_memreq_val <= 1'b1;
                  r_memreq_msg <= {c_type_read, 8'h00, w_tag, 4'h0, 4'h0, 128'h0};
                  r_state      <= ST_RR;
               end
            end
            ST_IN: begin
               r_valid[w_idx]  <= 1'b1;
               r_dirty[w_idx]  <= 1'b0;
               r_cacheresp_val <= 1'b1;
               r_cacheresp_msg <= {r_type, r_opaque, 1'b0, r_hit, 2'b00, 32'h0};
               r_state         <= ST_W;
            end
            ST_RD: begin
               r_cacheresp_val <= 1'b1;
               r_cacheresp_msg <= {r_type, r_opaque, 1'b0, r_hit, 2'b00, w_word_rd};
               r_state         <= ST_W;
            end
            ST_WD: begin
               r_dirty[w_idx]  <= 1'b1;
               r_cacheresp_val <= 1'b1;
               r_cacheresp_msg <= {r_type, r_opaque, 1'b0, r_hit, 2'b00, 32'h0};
               r_state         <= ST_W;
            end
            ST_EP: begin
               // The memreq message register doubles as the victim buffer.
               r_memreq_val <= 1'b1;
               r_memreq_msg <= {c_type_write, 8'h00, r_tag_array[w_idx], 4'h0, 4'h0, w_line_rd};
               r_state      <= ST_ER;
            end
            ST_ER: begin
               if (memreq.rdy) begin
                  r_memreq_val  <= 1'b0;
                  r_memresp_rdy <= 1'b1;
                  r_state       <= ST_EW;
               end
            end
            ST_EW: begin
               if (memresp.val) begin
                  r_memresp_rdy <= 1'b0;
                  r_memreq_val  <= 1'b1;
                  r_memreq_msg  <= {c_type_read, 8'h00, w_tag, 4'h0, 4'h0, 128'h0};
                  r_state       <= ST_RR;
               end
            end
            ST_RR: begin
               if (memreq.rdy) begin
                  r_memreq_val  <= 1'b0;
                  r_memresp_rdy <= 1'b1;
                  r_state       <= ST_RW;
               end
            end
            ST_RW: begin
               if (memresp.val) begin
                  r_line        <= memresp.msg[127:0];
                  r_memresp_rdy <= 1'b0;
                  r_state       <= ST_RU;
               end
            end
            ST_RU: begin
               r_valid[w_idx] <= 1'b1;
               r_dirty[w_idx] <= 1'b0;
               r_state        <= w_is_write ? ST_WD : ST_RD;
            end
            ST_W: begin
               if (cacheresp.rdy) begin
                  r_cacheresp_val <= 1'b0;
                  r_cacheresp_msg <= '0;
                  r_cachereq_rdy  <= 1'b1;
                  r_state         <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_lab3_mem_blocking_cache_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lab3_mem_blocking_cache_param
// Brief    : Self-checking bench: directed scenarios followed by random
//            READ/WRITE traffic against a residency + flat-memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lab3_mem_blocking_cache_param;
   localparam int c_lines = 16;
   localparam int c_shamt = 0;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   lab3_mem_blocking_cache_param_if #(.MSG_W(77))  cachereq  ();
   lab3_mem_blocking_cache_param_if #(.MSG_W(47))  cacheresp ();
   lab3_mem_blocking_cache_param_if #(.MSG_W(175)) memreq    ();
   lab3_mem_blocking_cache_param_if #(.MSG_W(145)) memresp   ();

   lab3_mem_blocking_cache_param #(.p_num_lines(c_lines), .p_idx_shamt(c_shamt)) dut (
      .clk       (clk),
      .reset     (reset),
      .cachereq  (cachereq),
      .cacheresp (cacheresp),
      .memreq    (memreq),
      .memresp   (memresp)
   );

   // Residency model: which line tag occupies each index and whether it is dirty.
   bit          mdl_valid [c_lines];
   bit          mdl_dirty [c_lines];
   logic [27:0] mdl_tag   [c_lines];
   // Architectural word values (keyed by word address) and the backing store.
   logic [31:0]  arch [int unsigned];
   logic [127:0] bmem [int unsigned];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      if (a[31:4] == 28'h0000200) return 32'(a[3:2]) + 32'd1;
      return a ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [127:0] l;
      if (bmem.exists(int'(a[31:4]))) begin
         l = bmem[int'(a[31:4])];
         return l[{a[3:2], 5'b00000} +: 32];
      end
      return init_word(a);
   endfunction

   function automatic logic [31:0] arch_word(input logic [31:0] a);
      if (arch.exists(int'(a[31:2]))) return arch[int'(a[31:2])];
      return mem_word(a);
   endfunction

   function automatic logic [127:0] mem_line(input logic [31:0] la);
      logic [127:0] l;
      for (int w = 0; w < 4; w++) l[w*32 +: 32] = mem_word(la + 32'(4*w));
      return l;
   endfunction

   function automatic logic [127:0] arch_line(input logic [31:0] la);
      logic [127:0] l;
      for (int w = 0; w < 4; w++) l[w*32 +: 32] = arch_word(la + 32'(4*w));
      return l;
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> (4 + c_shamt)) & 32'(c_lines - 1));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < c_lines; i++) begin
         mdl_valid[i] = 1'b0;
         mdl_dirty[i] = 1'b0;
         mdl_tag[i]   = '0;
      end
      arch.delete();
   endtask

   // Plays the memory: checks one memreq, stalls it, then answers it.
   task automatic mem_xact(input logic [2:0] typ, input logic [31:0] addr,
                           input logic [127:0] data, input int hold, input bit no_resp);
      logic [174:0] exp_msg;
      int n;
      exp_msg = {typ, 8'h00, addr, 4'h0, data};
      n = 0;
      while (memreq.val !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("memreq_val", 256'(memreq.val), 256'(1'b1));
      chk("memreq_msg", 256'(memreq.msg), 256'(exp_msg));
      chk("memresp_rdy_not_waiting", 256'(memresp.rdy), 256'(1'b0));
      // A stray response offered now must be ignored.
      if (hold > 0) begin
         memresp.val = 1'b1;
         memresp.msg = {3'd0, 8'h00, 2'b00, 4'h0, {4{32'hBAD0BAD0}}};
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("memreq_hold_stable", 256'({memreq.val, memreq.msg}), 256'({1'b1, exp_msg}));
      end
      memresp.val = 1'b0;
      memreq.rdy  = 1'b1;
      @(negedge clk);
      memreq.rdy  = 1'b0;
      if (typ == 3'd1) bmem[int'(addr[31:4])] = data;
      n = 0;
      while (memresp.rdy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("memresp_rdy", 256'(memresp.rdy), 256'(1'b1));
      if (no_resp) return;
      memresp.msg = {typ, 8'h00, 2'b00, 4'h0, (typ == 3'd0) ? mem_line(addr) : 128'h0};
      memresp.val = 1'b1;
      @(negedge clk);
      memresp.val = 1'b0;
      memresp.msg = '0;
   endtask

   // One processor transaction, with the expected memory traffic and response
   // derived from the model; abort pulls reset while the refill is outstanding.
   task automatic xact(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] data,
                       input int hold, input int stall, input bit abort);
      int          ix, n, lat;
      logic [27:0] tg;
      bit          is_wr, is_init, hit, evict, refill;
      logic [7:0]  opq;
      logic [31:0] exp_data;
      logic [46:0] exp_resp;
      ix      = idx_of(addr);
      tg      = addr[31:4];
      is_wr   = (typ == 3'd1);
      is_init = (typ == 3'd2);
      hit     = mdl_valid[ix] && (mdl_tag[ix] == tg);
      refill  = !is_init && !hit;
      evict   = refill && mdl_valid[ix] && mdl_dirty[ix];
      opq     = 8'($urandom);
      exp_data = (is_wr || is_init) ? 32'h0 : arch_word(addr);
      exp_resp = {typ, opq, 1'b0, hit && !is_init, 2'b00, exp_data};

      n = 0;
      while (cachereq.rdy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("cachereq_rdy", 256'(cachereq.rdy), 256'(1'b1));
      cachereq.msg = {typ, opq, addr, 2'b00, data};
      cachereq.val = 1'b1;
      @(negedge clk);
      cachereq.val = 1'b0;
      cachereq.msg = '0;

      if (evict) mem_xact(3'd1, {mdl_tag[ix], 4'h0}, arch_line({mdl_tag[ix], 4'h0}), hold, 1'b0);
      if (refill) mem_xact(3'd0, {tg, 4'h0}, 128'h0, hold, abort);

      if (abort) begin
         reset = 1'b0;
         #1;
         chk("abort_outputs_zero",
             256'({cachereq.rdy, cacheresp.val, memreq.val, memresp.rdy, cacheresp.msg, memreq.msg}),
             256'(0));
         repeat (3) @(negedge clk);
         reset = 1'b1;
         repeat (3) @(negedge clk);
         chk("abort_quiet_after", 256'({cacheresp.val, memreq.val, memresp.rdy}), 256'(0));
         model_reset();
         return;
      end

      lat = 0;
      while (cacheresp.val !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
      if (!refill) chk("hit_latency", 256'(lat), 256'(2));
      chk("cacheresp_val", 256'(cacheresp.val), 256'(1'b1));
      chk("cacheresp_msg", 256'(cacheresp.msg), 256'(exp_resp));
      chk("busy_no_req_no_mem", 256'({cachereq.rdy, memreq.val}), 256'(0));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("cacheresp_stall_stable", 256'({cacheresp.val, cacheresp.msg}), 256'({1'b1, exp_resp}));
      end
      cacheresp.rdy = 1'b1;
      @(negedge clk);
      cacheresp.rdy = 1'b0;
      chk("cacheresp_val_dropped", 256'(cacheresp.val), 256'(1'b0));

      if (is_wr || is_init) arch[int'(addr[31:2])] = data;
      mdl_dirty[ix] = is_wr ? 1'b1 : (is_init ? 1'b0 : (hit && mdl_dirty[ix]));
      mdl_valid[ix] = 1'b1;
      mdl_tag[ix]   = tg;
   endtask

   // Directed scenarios, then random traffic, then a mid-refill reset.
   initial begin
      logic [2:0]  rtyp;
      logic [31:0] raddr;
      int          r;
      cachereq.val  = 1'b0;
      cachereq.msg  = '0;
      cacheresp.rdy = 1'b0;
      memreq.rdy    = 1'b0;
      memresp.val   = 1'b0;
      memresp.msg   = '0;
      model_reset();

      repeat (3) @(negedge clk);
      chk("reset_outputs_zero",
          256'({cachereq.rdy, cacheresp.val, memreq.val, memresp.rdy, cacheresp.msg, memreq.msg}),
          256'(0));
      reset = 1'b1;
      @(negedge clk);
      chk("rdy_after_reset", 256'(cachereq.rdy), 256'(1'b1));

      xact(3'd2, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 1'b0);
      xact(3'd0, 32'h0000_1000, 32'h0,         0, 0, 1'b0);
      xact(3'd0, 32'h0000_2004, 32'h0,         0, 0, 1'b0);
      xact(3'd0, 32'h0000_2004, 32'h0,         0, 0, 1'b0);
      xact(3'd0, 32'h0000_200C, 32'h0,         0, 0, 1'b0);
      xact(3'd1, 32'h0000_3008, 32'h0000_00AB, 0, 0, 1'b0);
      xact(3'd0, 32'h0000_3008, 32'h0,         0, 0, 1'b0);
      xact(3'd1, 32'h0000_0000, 32'h0000_0011, 0, 0, 1'b0);
      xact(3'd0, 32'h0000_0100, 32'h0,         0, 0, 1'b0);
      xact(3'd0, 32'h0000_0200, 32'h0,         0, 0, 1'b0);
      xact(3'd0, 32'h0000_0300, 32'h0,         0, 0, 1'b0);
      xact(3'd0, 32'h0000_2010, 32'h0,         5, 3, 1'b0);

      for (int k = 0; k < 200; k++) begin
         r     = int'($urandom_range(0, 9));
         rtyp  = (r < 5) ? 3'd0 : ((r < 9) ? 3'd1 : 3'd3);
         raddr = 32'h0000_2000 + (32'($urandom_range(0, 255)) << 2);
         xact(rtyp, raddr, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
      end

      xact(3'd0, 32'h0000_4440, 32'h0, 0, 0, 1'b1);
      xact(3'd0, 32'h0000_4440, 32'h0, 0, 0, 1'b0);
      xact(3'd0, 32'h0000_4444, 32'h0, 0, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
